// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared branch codes, counter encodings and the saturating-step helper.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BGEZAL, BLTZAL
    } br_code_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic cnt_e cnt_next(input cnt_e c, input logic inc);
        return inc ? (c == ST  ? ST  : cnt_e'(c + 2'd1))
                   : (c == SNT ? SNT : cnt_e'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: 2-bit saturating up/down counter with enable and a load
// path used when a BHT entry is reclaimed by a new branch.
module sat_counter2
    import branch_predictor_pkg::*;
#(
    parameter cnt_e RST_VAL = WNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_inc,
    input  logic i_load,
    input  cnt_e i_load_val,
    output cnt_e o_cnt
);

    cnt_e r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= RST_VAL;
        else if (i_en)
            r_cnt <= i_load ? i_load_val : cnt_next(r_cnt, i_inc);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT + BTB predicting in IF, trained by
// the EX-stage branch unit, flagging mispredicts with a redirect PC.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int          IDX_W   = 6,
    parameter int          TAG_W   = 8,
    parameter logic [1:0]  CNT_RST = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_stat_branches,
    output logic [31:0] o_stat_mispred
);

    localparam int N = 1 << IDX_W;

    logic             r_valid [N];
    logic [TAG_W-1:0] r_tag   [N];
    logic [31:0]      r_tgt   [N];
    logic [1:0]       w_cnt   [N];
    logic [31:0]      r_branches;
    logic [31:0]      r_mispred;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_upd;
    logic             w_mispred;

    assign w_if_idx = i_if_pc[IDX_W+1:2];
    assign w_if_tag = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Predictions read the registered tables, so a same-cycle update is seen next cycle.
    assign w_if_hit      = r_valid[w_if_idx] && r_tag[w_if_idx] == w_if_tag;
    assign w_ex_hit      = r_valid[w_ex_idx] && r_tag[w_ex_idx] == w_ex_tag;
    assign o_pred_taken  = w_if_hit && w_cnt[w_if_idx][1];
    assign o_pred_target = o_pred_taken ? r_tgt[w_if_idx] : i_if_pc + PC_INC;

    assign w_mispred     = i_ex_valid && (i_ex_taken != i_ex_pred_taken ||
                                          (i_ex_taken && i_ex_target != i_ex_pred_target));
    assign o_mispredict  = rst_n && w_mispred;
    assign o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + PC_INC;
    assign w_upd         = i_ex_valid && !i_stall;

    // A taken branch that misses claims the entry and restarts its counter at WT;
    // a not-taken miss leaves the other branch's state alone.
    for (genvar g = 0; g < N; g++) begin : g_cnt
        sat_counter2 #(.RST_VAL(cnt_e'(CNT_RST))) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_en       (w_upd && w_ex_idx == IDX_W'(g) && (w_ex_hit || i_ex_taken)),
            .i_inc      (i_ex_taken),
            .i_load     (!w_ex_hit),
            .i_load_val (WT),
            .o_cnt      (w_cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_valid[k] <= 1'b0;
                r_tag[k]   <= '0;
                r_tgt[k]   <= '0;
            end
        end else if (w_upd && i_ex_taken) begin
            r_valid[w_ex_idx] <= 1'b1;
            r_tag[w_ex_idx]   <= w_ex_tag;
            r_tgt[w_ex_idx]   <= i_ex_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branches <= '0;
            r_mispred  <= '0;
        end else if (w_upd) begin
            r_branches <= r_branches + 32'd1;
            r_mispred  <= r_mispred + {31'd0, w_mispred};
        end
    end

    assign o_stat_branches = r_branches;
    assign o_stat_mispred  = r_mispred;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed steps with hand-computed expectations for the branch predictor.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h40;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_stall          (stall),
        .i_ex_valid       (ex_valid),
        .i_ex_pc          (ex_pc),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_target (ex_pred_target),
        .o_mispredict     (mispredict),
        .o_redirect_pc    (redirect_pc),
        .o_stat_branches  (stat_branches),
        .o_stat_mispred   (stat_mispred)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pred(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
        @(negedge clk);
        if_pc = pc;
        #1;
        chk({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({tag, "_tgt"}, pred_target, exp_tgt);
    endtask

    task automatic ex(input string tag, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                      input logic exp_mis, input logic [31:0] exp_redir);
        @(negedge clk);
        ex_valid = 1'b1;
        ex_pc = pc;
        ex_taken = tk;
        ex_target = tgt;
        ex_pred_taken = ptk;
        ex_pred_target = ptgt;
        #1;
        chk({tag, "_mis"}, {31'd0, mispredict}, {31'd0, exp_mis});
        chk({tag, "_redir"}, redirect_pc, exp_redir);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mis);
        chk({tag, "_br"}, stat_branches, br);
        chk({tag, "_mis"}, stat_mispred, mis);
    endtask

    initial begin
        // reset: mispredict held low even with a mismatching EX branch
        ex_valid = 1'b1;
        ex_pc = 32'h40;
        ex_taken = 1'b1;
        ex_target = 32'h80;
        #1;
        chk("rst_tk", {31'd0, pred_taken}, 32'd0);
        chk("rst_tgt", pred_target, 32'h44);
        chk("rst_mis", {31'd0, mispredict}, 32'd0);
        stats("rst", 32'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_br", stat_branches, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;

        ex("first", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1, 32'h80);
        stats("first", 32'd1, 32'd1);
        pred("first_p", 32'h40, 1'b1, 32'h80);

        ex("t1", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        ex("t2", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        ex("t3", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        pred("strong_p", 32'h40, 1'b1, 32'h80);
        ex("nt1", 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
        pred("nt1_p", 32'h40, 1'b1, 32'h80);
        ex("nt2", 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
        pred("nt2_p", 32'h40, 1'b0, 32'h44);
        stats("ctr", 32'd6, 32'd3);

        // alias: same index, different tag, replaces the entry
        ex("alias", 32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b1, 32'h200);
        pred("alias_old", 32'h40, 1'b0, 32'h44);
        pred("alias_new", 32'h140, 1'b1, 32'h200);

        ex("wtgt", 32'h140, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
        pred("wtgt_p", 32'h140, 1'b1, 32'h90);
        stats("wtgt", 32'd8, 32'd5);

        // stalled updates leave every table and stat alone
        stall = 1'b1;
        ex("stall_nt", 32'h140, 1'b0, 32'h90, 1'b1, 32'h90, 1'b1, 32'h144);
        ex("stall_tk", 32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1, 32'h300);
        stats("stall", 32'd8, 32'd5);
        pred("stall_p140", 32'h140, 1'b1, 32'h90);
        pred("stall_p80", 32'h80, 1'b0, 32'h84);
        stall = 1'b0;

        // not-taken miss on an empty entry must not allocate
        ex("ntmiss", 32'h80, 1'b0, 32'h300, 1'b0, 32'h84, 1'b0, 32'h84);
        pred("ntmiss_p", 32'h80, 1'b0, 32'h84);

        // same-index predict and update in one cycle
        @(negedge clk);
        if_pc = 32'h80;
        ex_valid = 1'b1;
        ex_pc = 32'h80;
        ex_taken = 1'b1;
        ex_target = 32'h300;
        ex_pred_taken = 1'b0;
        ex_pred_target = 32'h84;
        #1;
        chk("same_old_tk", {31'd0, pred_taken}, 32'd0);
        chk("same_old_tgt", pred_target, 32'h84);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #1;
        chk("same_new_tk", {31'd0, pred_taken}, 32'd1);
        chk("same_new_tgt", pred_target, 32'h300);
        stats("same", 32'd10, 32'd6);

        // async reset mid-update clears everything immediately
        @(negedge clk);
        ex_valid = 1'b1;
        ex_pc = 32'h140;
        ex_taken = 1'b1;
        ex_target = 32'h500;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_tk", {31'd0, pred_taken}, 32'd0);
        chk("arst_tgt", pred_target, 32'h84);
        chk("arst_mis", {31'd0, mispredict}, 32'd0);
        stats("arst", 32'd0, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        pred("arst_p140", 32'h140, 1'b0, 32'h144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
